ahb_region_router: RTL
======================

Name: ahb_region_router

Overview:
- Sits directly downstream of the physical-address decoder in the uncore AHB fabric.
- Consumes the one-hot region selects in the address phase and drives per-slave HSEL.
- Registers the selection into the data phase, then muxes the selected slave's HREADYOUT/HRESP/HRDATA back to the master.
- Acts as default slave for unmapped addresses (two-cycle AHB ERROR) and as a watchdog that errors out and fences any slave stalling beyond TIMEOUT cycles.

Parameters:
- XLEN, 64, data bus width.
- NREGIONS, 14, width of region-select vector; bit 0 = "no region".
- TIMEOUT, 256, max consecutive wait-state cycles allowed from a selected slave (>=2).
- CNTW, $clog2(TIMEOUT), watchdog counter width.

Ports:
- HCLK  in  1  clock; all state on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- SelRegions  in  NREGIONS  one-hot region select from address decoder (address phase).
- HTRANS  in  2  AHB transfer type from master.
- HSELSlaves  out  NREGIONS  per-slave address-phase select; bit 0 always 0.
- HREADYOUTSlaves  in  NREGIONS  per-slave ready; bit 0 ignored.
- HRESPSlaves  in  NREGIONS  per-slave error response; bit 0 ignored.
- HRDATASlaves  in  NREGIONS*XLEN  per-slave read data, slice i = [i*XLEN +: XLEN]; slice 0 ignored.
- HREADY  out  1  global ready to master and all slaves.
- HRESP  out  1  response to master.
- HRDATA  out  XLEN  read data to master.
- HungMask  out  NREGIONS  sticky per-region timeout flags; bit 0 always 0.

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is synchronous, active-low.
- Reset values:
  - DataSel = 0, state = IDLE, counter = 0, HungMask = 0.
  - Outputs: HREADY=1, HRESP=0, HRDATA=0, HSELSlaves=0.
- Address phase (combinational):
  - Active = HTRANS[1].
  - Region pick: lowest-indexed set bit of SelRegions[NREGIONS-1:1]; if none is set, the pick is region 0.
  - If the picked region i has HungMask[i]=1, the pick becomes region 0.
  - HSELSlaves[i] = Active & (pick==i), for i>=1.
- Accept: transfer accepted on an edge where HREADY=1 & Active.
  - DataSel <= one-hot pick. If the pick is region 0, state <= ERR1.
  - Edge with HREADY=1 & ~Active: DataSel <= 0 (idle data phase).
  - HREADY=0: DataSel holds.
- Data phase, DataSel=0: HREADY=1, HRESP=0, HRDATA=0.
- Data phase, DataSel[i], i>=1, state IDLE:
  - HREADY = HREADYOUTSlaves[i], HRESP = HRESPSlaves[i], HRDATA = slice i.
- Error FSM (default slave / timeout):
  - IDLE -> ERR1 on accept of region 0, or on watchdog expiry.
  - ERR1: HREADY=0, HRESP=1, HRDATA=0; next state ERR2.
  - ERR2: HREADY=1, HRESP=1, HRDATA=0; next state IDLE. A new address phase is accepted on this edge per the normal accept rule, and may re-enter ERR1 if it targets region 0.
  - HTRANS changes during ERR1 are ignored.
- Watchdog:
  - Counter increments on each edge in state IDLE with DataSel[i], i>=1, and HREADYOUTSlaves[i]=0.
  - Counter clears on any edge with HREADY=1.
  - If the counter == TIMEOUT-1 and the slave ready is still 0, then on that edge:
    - state <= ERR1, HungMask[i] <= 1, counter <= 0.
  - Resulting sequence: exactly TIMEOUT slave wait cycles, then ERR1, then ERR2.
  - Slave outputs are ignored while in ERR1/ERR2. A late HREADYOUT from the hung slave is discarded.
- HungMask is sticky until reset. A hung region is thereafter treated as unmapped and its HSEL is never asserted.
- Reset mid-transfer (including ERR1/ERR2 or mid-count) returns all state to reset values on that edge.
- HRDATA is the combinational mux only; no data is registered.

Test Plan:
- Reset: HRESETn=0 for 2 cycles with arbitrary inputs -> HREADY=1, HRESP=0, HRDATA=0, HSELSlaves=0, HungMask=0.
- Mapped read: SelRegions=14'h0040, HTRANS=2'b10; slave 6 returns ready=0 then 1, data 64'hDEADBEEF_00000006 -> HSELSlaves[6]=1 in the address cycle; HREADY 0 then 1; HRDATA matches; HRESP=0.
- Unmapped: SelRegions=14'h0001, HTRANS=NONSEQ -> no HSEL; next cycle HREADY=0/HRESP=1; following cycle HREADY=1/HRESP=1; then idle HREADY=1/HRESP=0.
- Back-to-back pipeline: region 3 then region 8 on consecutive HREADY=1 cycles -> each data phase returns its own slave's data; HSELSlaves[8] coincides with region 3's data phase.
- Watchdog (TIMEOUT=8): slave 5 holds HREADYOUT=0 -> 8 cycles of HREADY=0, then ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1); HungMask=14'h0020. A subsequent access to region 5 gets the unmapped two-cycle error with HSELSlaves[5]=0.
- Multi-hot plus reset: SelRegions=14'h0210 -> region 4 selected. Assert HRESETn=0 during ERR1 of a later unmapped access -> next cycle HREADY=1, HRESP=0, state IDLE.

Source files
------------

// File: rtl/ahb_region_router.sv
// ---------------------------------------------------------------------------
// ahb_region_router
//
// Purpose:
//   Sits behind the physical-address decoder on the uncore AHB fabric. It turns
//   the decoder's one-hot region selects into per-slave HSEL during the address
//   phase. It then remembers which slave owns the data phase and muxes that
//   slave's HREADYOUT/HRESP/HRDATA back to the master.
//
//   The block also has two error roles:
//   - Default slave for unmapped addresses. Region 0, or a region that has been
//     fenced, gets the standard two-cycle AHB ERROR response.
//   - Watchdog. A slave that inserts TIMEOUT consecutive wait states is
//     answered with an ERROR on its behalf and fenced off until reset.
//
// Ports:
//   HCLK             clock, all state on the rising edge
//   HRESETn          synchronous active-low reset
//   SelRegions       one-hot region select from the address decoder (bit 0 = unmapped)
//   HTRANS           AHB transfer type from the master
//   HSELSlaves       per-slave address-phase select (bit 0 always 0)
//   HREADYOUTSlaves  per-slave ready (bit 0 ignored)
//   HRESPSlaves      per-slave error response (bit 0 ignored)
//   HRDATASlaves     per-slave read data, slice i = [i*XLEN +: XLEN] (slice 0 ignored)
//   HREADY           global ready to the master and all slaves
//   HRESP            response to the master
//   HRDATA           read data to the master
//   HungMask         sticky per-region timeout flags (bit 0 always 0)
// ---------------------------------------------------------------------------
module ahb_region_router #(
  parameter int XLEN     = 64,
  parameter int NREGIONS = 14,
  parameter int TIMEOUT  = 256,
  parameter int CNTW     = $clog2(TIMEOUT)
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NREGIONS-1:0]      SelRegions,
  input  logic [1:0]               HTRANS,
  output logic [NREGIONS-1:0]      HSELSlaves,
  input  logic [NREGIONS-1:0]      HREADYOUTSlaves,
  input  logic [NREGIONS-1:0]      HRESPSlaves,
  input  logic [NREGIONS*XLEN-1:0] HRDATASlaves,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [XLEN-1:0]          HRDATA,
  output logic [NREGIONS-1:0]      HungMask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } stateT;

  stateT               r_state, w_stateNext;
  logic [NREGIONS-1:0] r_dataSel, w_dataSelNext;
  logic [CNTW-1:0]     r_count, w_countNext;
  logic [NREGIONS-1:0] r_hungMask, w_hungMaskNext;

  logic                w_active;
  logic                w_found;
  logic [NREGIONS-1:0] w_pickOneHot;
  logic                w_dataMapped;
  logic                w_slvReady;
  logic                w_slvResp;
  logic [XLEN-1:0]     w_slvData;
  logic                w_unused;

  // Bit 0 of each per-slave bus belongs to the "no region" pseudo-slave. That
  // is this block itself, so those inputs carry nothing we need. HTRANS[0]
  // only distinguishes IDLE from BUSY and SEQ from NONSEQ, which routing does
  // not care about.
  assign w_unused = ^{HTRANS[0], HREADYOUTSlaves[0], HRESPSlaves[0], HRDATASlaves[XLEN-1:0]};

  assign w_active = HTRANS[1];

  // Address-phase region pick. The lowest set bit above bit 0 wins, so a
  // multi-hot decode from overlapping windows still selects exactly one slave.
  // A region fenced by the watchdog is demoted to region 0, which sends the
  // access to our own default-slave error path instead of the hung slave.
  always_comb begin
    w_pickOneHot = '0;
    w_found      = 1'b0;
    for (int i = 1; i < NREGIONS; i++) begin
      if (!w_found && SelRegions[i]) begin
        w_pickOneHot[i] = 1'b1;
        w_found         = 1'b1;
      end
    end
    if (|(w_pickOneHot & r_hungMask)) begin
      w_pickOneHot = '0;
    end
    if (w_pickOneHot == '0) begin
      w_pickOneHot[0] = 1'b1;
    end
  end

  // Slaves only ever see a select for a real region. Selects are also gated
  // by reset, so nothing downstream is addressed while the fabric is held.
  always_comb begin
    HSELSlaves = '0;
    if (w_active && HRESETn) begin
      HSELSlaves = {w_pickOneHot[NREGIONS-1:1], 1'b0};
    end
  end

  // Data-phase mux from the slave that owns the current data phase. r_dataSel
  // is one-hot or zero, so an AND-OR mux is enough.
  always_comb begin
    w_slvReady = 1'b0;
    w_slvResp  = 1'b0;
    w_slvData  = '0;
    for (int i = 1; i < NREGIONS; i++) begin
      if (r_dataSel[i]) begin
        w_slvReady = w_slvReady | HREADYOUTSlaves[i];
        w_slvResp  = w_slvResp  | HRESPSlaves[i];
        w_slvData  = w_slvData  | HRDATASlaves[i*XLEN +: XLEN];
      end
    end
  end

  assign w_dataMapped = |r_dataSel[NREGIONS-1:1];

  // Master-facing response. In the error states we drive the two-cycle ERROR
  // ourselves and ignore the slave completely, so a late HREADYOUT from a
  // hung slave cannot leak through.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    unique case (r_state)
      IDLE: begin
        if (w_dataMapped) begin
          HREADY = w_slvReady;
          HRESP  = w_slvResp;
          HRDATA = w_slvData;
        end
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end
    endcase
  end

  assign HungMask = r_hungMask;

  // Next-state logic for the data-phase owner, the error FSM and the watchdog.
  // Accepting an address phase to region 0 and a watchdog expiry cannot happen
  // on the same edge: the first needs HREADY=1, the second needs the owning
  // slave to be stalling HREADY low.
  always_comb begin
    w_stateNext    = r_state;
    w_dataSelNext  = r_dataSel;
    w_countNext    = r_count;
    w_hungMaskNext = r_hungMask;

    if (HREADY) begin
      w_countNext = '0;
      if (w_active) begin
        w_dataSelNext = w_pickOneHot;
        if (w_pickOneHot[0]) begin
          w_stateNext = ERR1;
        end else if (r_state == ERR2) begin
          w_stateNext = IDLE;
        end
      end else begin
        w_dataSelNext = '0;
        if (r_state == ERR2) begin
          w_stateNext = IDLE;
        end
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_dataMapped && !w_slvReady) begin
            if (r_count == CNTW'(TIMEOUT - 1)) begin
              w_stateNext    = ERR1;
              w_countNext    = '0;
              w_hungMaskNext = r_hungMask | {r_dataSel[NREGIONS-1:1], 1'b0};
            end else begin
              w_countNext = r_count + CNTW'(1);
            end
          end
        end
        ERR1: begin
          w_stateNext = ERR2;
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // State registers with synchronous reset. A reset in the middle of a
  // transfer, an error sequence or a watchdog count drops everything back to
  // idle on that edge and also clears the fence.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= IDLE;
      r_dataSel  <= '0;
      r_count    <= '0;
      r_hungMask <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_dataSel  <= w_dataSelNext;
      r_count    <= w_countNext;
      r_hungMask <= w_hungMaskNext;
    end
  end

endmodule
